expr_ci_ctrl: RTL and testbench

- CPU-facing responder for the fixed-latency floating-point expression datapath (fp_add -> cordic -> fp_mult -> fp_add -> fp_mult chain).
- Implements the Nios II multi-cycle custom-instruction handshake: clk_en, start, dataa, done, result.
- Registers the operand, holds it stable while the unpipelined datapath settles, counts the latency, captures the datapath output and pulses done for one cycle.
- One operation in flight; the datapath is instantiated beside this block in the custom-instruction top level.

---
 rtl/expr_pkg.sv | 22 ++
 rtl/expr_ci_ctrl_if.sv | 37 +++
 rtl/expr_ci_ctrl.sv | 123 ++++++++++++
 tb/tb_expr_ci_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// ---------------------------------------------------------------------------
// expr_pkg
// Shared definitions for the floating-point expression custom instruction:
// the controller state encoding and the default width/latency constants.
// ---------------------------------------------------------------------------
package expr_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int EXPR_DW      = 32;
    localparam int EXPR_LATENCY = 56;

    // Width and ceiling of the dropped-start counter
    localparam int          DROP_W   = 8;
    localparam logic [7:0]  DROP_MAX = 8'hFF;

endpackage : expr_pkg

// File: rtl/expr_ci_ctrl_if.sv
// ---------------------------------------------------------------------------
// expr_ci_ctrl_if
// Bundles the Nios II multi-cycle custom-instruction handshake together with
// the datapath-facing operand/result pair and the status outputs.
//   clk_en, start, dataa : CPU -> controller
//   done, result         : controller -> CPU
//   busy, drop_cnt       : controller status
//   dp_x                 : controller -> datapath operand
//   dp_result            : datapath -> controller result
// Modport slave is the controller; master is the CPU/datapath side.
// ---------------------------------------------------------------------------
interface expr_ci_ctrl_if
    import expr_pkg::*;
#(
    parameter int DW = EXPR_DW
);
    logic              clk_en;
    logic              start;
    logic [DW-1:0]     dataa;
    logic              done;
    logic [DW-1:0]     result;
    logic              busy;
    logic [DW-1:0]     dp_x;
    logic [DW-1:0]     dp_result;
    logic [DROP_W-1:0] drop_cnt;

    modport slave (
        input  clk_en, start, dataa, dp_result,
        output done, result, busy, dp_x, drop_cnt
    );

    modport master (
        output clk_en, start, dataa, dp_result,
        input  done, result, busy, dp_x, drop_cnt
    );

endinterface : expr_ci_ctrl_if

// File: rtl/expr_ci_ctrl.sv
// ---------------------------------------------------------------------------
// expr_ci_ctrl
// CPU-facing responder for the fixed-latency expression datapath. Latches the
// operand onto dp_x when a start is accepted, keeps it stable while the
// unpipelined datapath settles, counts LATENCY clock-enabled edges, captures
// dp_result and pulses done for one clock-enabled cycle.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (overrides clk_en)
//   bus   : expr_ci_ctrl_if.slave handshake / datapath / status bundle
// ---------------------------------------------------------------------------
module expr_ci_ctrl
    import expr_pkg::*;
#(
    parameter int DW      = EXPR_DW,
    parameter int LATENCY = EXPR_LATENCY
) (
    input  logic           clk,
    input  logic           reset,
    expr_ci_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    // A zero latency would leave no settle time between dp_x and capture
    if (LATENCY < 1) begin : g_bad_latency
        $error("expr_ci_ctrl: LATENCY must be >= 1");
    end

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DW-1:0]     dp_x_q,   dp_x_d;
    logic [DW-1:0]     result_q, result_d;
    logic              done_q,   done_d;
    logic              busy_q;
    logic [DROP_W-1:0] drop_q,   drop_d;

    // Next-state and datapath-register update; everything holds when clk_en is low
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dp_x_d   = dp_x_q;
        result_d = result_q;
        done_d   = done_q;
        drop_d   = drop_q;

        if (bus.clk_en) begin
            case (state_q)
                IDLE: begin
                    done_d = 1'b0;
                    if (bus.start) begin
                        dp_x_d  = bus.dataa;
                        cnt_d   = CNT_W'(LATENCY);
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    done_d = 1'b0;
                    // Starts arriving mid-operation are discarded but tallied
                    if (bus.start && (drop_q != DROP_MAX)) begin
                        drop_d = drop_q + 8'd1;
                    end else begin
                        drop_d = drop_q;
                    end
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        result_d = bus.dp_result;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    done_d = 1'b0;
                    // A start during the done cycle reissues without an IDLE gap
                    if (bus.start) begin
                        dp_x_d  = bus.dataa;
                        cnt_d   = CNT_W'(LATENCY);
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            dp_x_q   <= {DW{1'b0}};
            result_q <= {DW{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= {DROP_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dp_x_q   <= dp_x_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= (state_d == RUN);
            drop_q   <= drop_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.busy     = busy_q;
    assign bus.dp_x     = dp_x_q;
    assign bus.drop_cnt = drop_q;

endmodule : expr_ci_ctrl

// File: tb/tb_expr_ci_ctrl.sv
// ---------------------------------------------------------------------------
// tb_expr_ci_ctrl
// Directed bench for expr_ci_ctrl with an in-bench stand-in for the expression
// datapath (LATENCY-deep shift register computing dp_x ^ 32'hA5A5A5A5).
// ---------------------------------------------------------------------------
module tb_expr_ci_ctrl;
    import expr_pkg::*;

    localparam int DW      = 32;
    localparam int LATENCY = 56;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic clk;
    logic reset;

    expr_ci_ctrl_if #(.DW(DW)) bus ();

    expr_ci_ctrl #(.DW(DW), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stub (expr_dp_stub): free-running LATENCY-deep delay of dp_x ^ KEY
    logic [DW-1:0] pipe [LATENCY];
    always_ff @(posedge clk) begin
        pipe[0] <= bus.dp_x ^ KEY;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.dp_result = pipe[LATENCY-1];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen; returns edges taken (bounded)
    task automatic wait_done(input int already, output int edges);
        edges = already;
        for (int k = 0; k < 300; k++) begin
            step();
            edges++;
            if (bus.done === 1'b1) return;
        end
        edges = -1;
    endtask

    initial begin
        int  n;
        bit  saw_done;

        reset      = 1'b1;
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.dataa  = 32'h0;
        repeat (3) step();
        reset = 1'b0;

        // Reset then idle
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_done",   32'(bus.done),   32'h0);
            chk("idle_result", bus.result,      32'h0);
            chk("idle_busy",   32'(bus.busy),   32'h0);
            chk("idle_dp_x",   bus.dp_x,        32'h0);
        end

        // Single operation
        bus.start = 1'b1; bus.dataa = 32'h3F800000;
        step();                                   // E0
        bus.start = 1'b0; bus.dataa = 32'h0;
        chk("single_dp_x", bus.dp_x,       32'h3F800000);
        chk("single_busy", 32'(bus.busy),  32'h1);
        wait_done(0, n);
        chk("single_latency", 32'(n),      32'd57);
        chk("single_result",  bus.result,  32'h9A25A5A5);
        step();
        chk("single_done_fall", 32'(bus.done), 32'h0);
        chk("single_hold",      bus.result,    32'h9A25A5A5);
        chk("single_idle_busy", 32'(bus.busy), 32'h0);

        // clk_en stall mid-run
        bus.start = 1'b1; bus.dataa = 32'h3F800000;
        step();                                   // E0
        bus.start = 1'b0;
        repeat (20) step();
        chk("stall_cnt_pre", 32'(dut.cnt_q), 32'd36);
        bus.clk_en = 1'b0;
        bus.start  = 1'b1;                        // ignored while disabled
        repeat (10) step();
        bus.start  = 1'b0;
        chk("stall_cnt_post", 32'(dut.cnt_q),  32'd36);
        chk("stall_done",     32'(bus.done),   32'h0);
        chk("stall_busy",     32'(bus.busy),   32'h1);
        bus.clk_en = 1'b1;
        wait_done(0, n);
        chk("stall_remaining", 32'(n),     32'd37);
        chk("stall_result",    bus.result, 32'h9A25A5A5);
        chk("stall_drop",      32'(bus.drop_cnt), 32'h0);

        // Back-to-back issue from the DONE cycle
        bus.start = 1'b1; bus.dataa = 32'h40000000;
        step();
        bus.start = 1'b0; bus.dataa = 32'h0;
        chk("b2b_busy", 32'(bus.busy), 32'h1);
        chk("b2b_dp_x", bus.dp_x,      32'h40000000);
        chk("b2b_done", 32'(bus.done), 32'h0);
        chk("b2b_state", 32'(dut.state_q), 32'(RUN));
        wait_done(0, n);
        chk("b2b_latency", 32'(n),     32'd57);
        chk("b2b_result",  bus.result, 32'hE5A5A5A5);
        step();

        // Starts while busy are dropped
        bus.start = 1'b1; bus.dataa = 32'h3F800000;
        step();                                   // E0
        bus.start = 1'b0;
        repeat (5) step();
        bus.start = 1'b1; bus.dataa = 32'hFFFFFFFF;
        repeat (3) step();
        bus.start = 1'b0; bus.dataa = 32'h0;
        chk("busy_dp_x", bus.dp_x,          32'h3F800000);
        chk("busy_drop", 32'(bus.drop_cnt), 32'd3);
        wait_done(8, n);
        chk("busy_latency", 32'(n),     32'd57);
        chk("busy_result",  bus.result, 32'h9A25A5A5);
        step();

        // Reset mid-operation
        bus.start = 1'b1; bus.dataa = 32'h40000000;
        step();                                   // E0
        bus.start = 1'b0;
        repeat (19) step();
        reset = 1'b1;
        step();                                   // E0+20
        reset = 1'b0;
        chk("rst_state",  32'(dut.state_q),   32'(IDLE));
        chk("rst_done",   32'(bus.done),      32'h0);
        chk("rst_result", bus.result,         32'h0);
        chk("rst_busy",   32'(bus.busy),      32'h0);
        chk("rst_dp_x",   bus.dp_x,           32'h0);
        chk("rst_drop",   32'(bus.drop_cnt),  32'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        chk("rst_no_done", 32'(saw_done), 32'h0);
        bus.start = 1'b1; bus.dataa = 32'h3F800000;
        step();
        bus.start = 1'b0;
        wait_done(0, n);
        chk("rst_after_latency", 32'(n),     32'd57);
        chk("rst_after_result",  bus.result, 32'h9A25A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_expr_ci_ctrl
